xbus_decoder: RTL and testbench
===============================

# xbus_decoder

Parametrised, registered bus decoder for the picoVersat data bus. It generalises the fixed memory/regfile/LED/trap decode into N_SLV address windows with per-window base and size. It adds a ready/wait handshake so slaves may insert wait states, and a timeout watchdog that turns unmatched or hung accesses into a trap. It sits between the core's data port and the peripheral slaves; write data and write-enable go to slaves directly and are not routed through this block.

## Interface
- ADDR_W, 13, bus address width
- DATA_W, 32, bus data width
- N_SLV, 4, number of slave windows (1..16)
- SLV_BASE, all zeros, packed N_SLV*ADDR_W; slice k is base of window k, aligned to its size
- SLV_AW, all 1s, packed N_SLV*5; slice k is offset width of window k (1..ADDR_W-1)
- TIMEOUT, 16, maximum wait cycles per access (2..255)
- clk  in  1  bus clock
- rst_n  in  1  reset, asynchronous, active-low
- m_sel  in  1  master request, held until m_ready
- m_we  in  1  1 = write, 0 = read, held with m_sel
- m_addr  in  ADDR_W  request address, held with m_sel
- m_ready  out  1  one-cycle completion pulse
- m_rdata  out  DATA_W  registered read data, valid when m_ready=1
- m_trap  out  1  one-cycle pulse, coincident with m_ready, on decode miss or timeout
- trap_addr  out  ADDR_W  address of the most recent trapped access
- s_sel  out  N_SLV  one-hot slave select
- s_ready  in  N_SLV  per-slave completion
- s_rdata  in  N_SLV*DATA_W  per-slave read data, slice k from slave k

## Operation
- Decode: window k hits when (m_addr & ~((1<<SLV_AW[k])-1)) == SLV_BASE[k]. Overlapping windows resolve to the lowest k. No hit is a miss.
- FSM states: IDLE, BUSY, RESP.
- IDLE, m_sel=1, hit k: register index k, clear the wait counter, go to BUSY.
- IDLE, m_sel=1, miss: set the trap flag, capture trap_addr, go to RESP. s_sel is never asserted.
- BUSY: s_sel[k]=1.
  - s_ready[k]=1: capture s_rdata[k] into m_rdata if the access is a read, go to RESP.
  - Otherwise increment the counter. When counter == TIMEOUT-1, set the trap flag, capture trap_addr, load m_rdata=0, go to RESP.
- RESP: m_ready=1, and m_trap equals the trap flag. m_sel is ignored in RESP. Next state is IDLE unconditionally.
- s_ready from unselected slaves is ignored at all times.
- s_ready[k] in the same cycle the counter reaches TIMEOUT-1: ready wins and no trap is raised.
- Writes: m_rdata holds its previous value, except a write timeout, which loads 0.
- Reset, including mid-transaction: state=IDLE, s_sel=0, m_ready=0, m_trap=0, m_rdata=0, trap_addr=0, counter=0. An interrupted access is dropped silently.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from m_* or s_* to any output.
- Request accepted at edge 0 in IDLE. s_sel high from cycle 1.
- Slave with 0 wait states (s_ready in cycle 1): m_ready in cycle 2. Minimum latency is 2 cycles.
- Slave with w wait states: m_ready in cycle 2+w.
- Miss: m_ready and m_trap in cycle 1.
- Timeout: s_sel high for exactly TIMEOUT cycles, then m_ready and m_trap in cycle TIMEOUT+1.
- Back-to-back: a new request can be accepted in the cycle after RESP, so the minimum period is 3 cycles.

## Structure
- Shared package/header (xdefs.vh): state encodings, the default SLV_BASE/SLV_AW map matching the current MEM/REGF/LED bases, and TIMEOUT default.
- One sub-module, xbus_win_match: combinational window comparator for a single window (addr, base, aw -> hit), instantiated N_SLV times with a priority encoder in the parent.
- Counter width is $clog2(TIMEOUT).

## Test plan
- Read, window 1 (base 0x1000, AW 8), addr 0x1004, s_ready[1] in cycle 1, s_rdata[1]=0xDEADBEEF -> s_sel=4'b0010 in cycle 1 only; m_ready and m_rdata=0xDEADBEEF in cycle 2; m_trap=0.
- Read, 3 wait states on window 0 -> s_sel[0] high cycles 1-4; m_ready in cycle 5 with correct data.
- Miss at addr 0x1F00 -> s_sel stays 0; m_ready=m_trap=1 in cycle 1; trap_addr=0x1F00.
- Timeout, TIMEOUT=16, s_ready held 0 -> s_sel high 16 cycles; m_trap and m_ready in cycle 17; m_rdata=0.
- s_ready asserted in the final timeout cycle -> normal completion, m_trap=0.
- Additional directed cases:
  - Overlapping windows 0 and 2 -> only s_sel[0] asserts.
  - Spurious s_ready[3] while slave 1 is busy -> ignored.
  - rst_n low in BUSY -> all outputs 0 immediately; a following request completes normally.

Source files
------------

// File: rtl/xbus_decoder_pkg.sv
// xbus_decoder_pkg
// Shared definitions for the picoVersat data-bus decoder:
//   - FSM state encoding
//   - default address map (memory / register file / alias / LED)
//   - default timeout
package xbus_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } xbus_state_t;

  localparam int XB_ADDR_W  = 13;
  localparam int XB_DATA_W  = 32;
  localparam int XB_N_SLV   = 4;
  localparam int XB_TIMEOUT = 16;

  // Default map, slice 0 in the LSBs:
  //   window 0: memory        0x0000, 4 KiB words (AW 12)
  //   window 1: register file 0x1000, AW 8
  //   window 2: low-memory alias 0x0000, AW 4 (shadowed by window 0)
  //   window 3: LED / misc    0x1200, AW 4
  localparam logic [XB_N_SLV*XB_ADDR_W-1:0] XB_SLV_BASE =
    {13'h1200, 13'h0000, 13'h1000, 13'h0000};
  localparam logic [XB_N_SLV*5-1:0] XB_SLV_AW =
    {5'd4, 5'd4, 5'd8, 5'd12};

endpackage

// File: rtl/xbus_win_match.sv
// xbus_win_match
// Combinational comparator for one address window.
//   addr : request address
//   base : window base, aligned to the window size
//   aw   : number of offset bits (window size = 1 << aw)
//   hit  : addr lies inside the window
module xbus_win_match #(
  parameter int ADDR_W = 13
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [4:0]        aw,
  output logic              hit
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] low_mask;

  // Offset bits are masked off before comparing against the base.
  assign low_mask = (ONE << aw) - ONE;
  assign hit      = ((addr & ~low_mask) == base);

endmodule

// File: rtl/xbus_decoder.sv
// xbus_decoder
// Registered data-bus decoder with N_SLV address windows, slave wait-state
// handshake and a timeout watchdog that converts misses/hangs into traps.
//   clk, rst_n           : clock, asynchronous active-low reset
//   m_sel/m_we/m_addr    : master request, held until m_ready
//   m_ready/m_rdata      : one-cycle completion pulse with registered read data
//   m_trap/trap_addr     : trap pulse (with m_ready) and last trapped address
//   s_sel                : one-hot slave select, high while the access is busy
//   s_ready/s_rdata      : per-slave completion and read data
module xbus_decoder
  import xbus_decoder_pkg::*;
#(
  parameter int                      ADDR_W   = 13,
  parameter int                      DATA_W   = 32,
  parameter int                      N_SLV    = 4,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*5-1:0]      SLV_AW   = {N_SLV{5'd1}},
  parameter int                      TIMEOUT  = XB_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m_sel,
  input  logic                    m_we,
  input  logic [ADDR_W-1:0]       m_addr,
  output logic                    m_ready,
  output logic [DATA_W-1:0]       m_rdata,
  output logic                    m_trap,
  output logic [ADDR_W-1:0]       trap_addr,
  output logic [N_SLV-1:0]        s_sel,
  input  logic [N_SLV-1:0]        s_ready,
  input  logic [N_SLV*DATA_W-1:0] s_rdata
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  xbus_state_t         state_reg, state_next;
  logic [N_SLV-1:0]    sel_reg, sel_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                trap_reg, trap_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic [ADDR_W-1:0]   taddr_reg, taddr_next;

  logic [N_SLV-1:0]    hit_vec;
  logic [N_SLV-1:0]    first_hit;
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLV; gi++) begin : g_win
      xbus_win_match #(.ADDR_W(ADDR_W)) u_win (
        .addr (m_addr),
        .base (SLV_BASE[gi*ADDR_W +: ADDR_W]),
        .aw   (SLV_AW[gi*5 +: 5]),
        .hit  (hit_vec[gi])
      );
    end
  endgenerate

  // Isolate the lowest set bit: overlapping windows resolve to the lowest k.
  assign first_hit = hit_vec & (~hit_vec + N_SLV'(1));

  // Only the latched slave may complete the access.
  assign sel_ready = |(s_ready & sel_reg);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (sel_reg[k]) sel_rdata = sel_rdata | s_rdata[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    trap_next  = trap_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    rdata_next = rdata_reg;
    taddr_next = taddr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (m_sel) begin
          we_next   = m_we;
          addr_next = m_addr;
          if (|hit_vec) begin
            sel_next   = first_hit;
            cnt_next   = '0;
            trap_next  = 1'b0;
            state_next = ST_BUSY;
          end else begin
            trap_next  = 1'b1;
            taddr_next = m_addr;
            state_next = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        // Ready is checked first so it wins over a same-cycle timeout.
        if (sel_ready) begin
          if (!we_reg) rdata_next = sel_rdata;
          state_next = ST_RESP;
        end else if (cnt_reg == CNT_LAST) begin
          trap_next  = 1'b1;
          taddr_next = addr_reg;
          rdata_next = '0;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      sel_reg   <= '0;
      cnt_reg   <= '0;
      trap_reg  <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      rdata_reg <= '0;
      taddr_reg <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
      trap_reg  <= trap_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      rdata_reg <= rdata_next;
      taddr_reg <= taddr_next;
    end
  end

  // Outputs depend on registered state only.
  assign s_sel     = (state_reg == ST_BUSY) ? sel_reg : '0;
  assign m_ready   = (state_reg == ST_RESP);
  assign m_trap    = (state_reg == ST_RESP) & trap_reg;
  assign m_rdata   = rdata_reg;
  assign trap_addr = taddr_reg;

endmodule

// File: tb/tb_xbus_decoder.sv
module tb_xbus_decoder;
  import xbus_decoder_pkg::*;

  localparam int AW = XB_ADDR_W;
  localparam int DW = XB_DATA_W;
  localparam int NS = XB_N_SLV;
  localparam int TO = XB_TIMEOUT;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    int            waits;      // cycle (minus 1) of s_ready; -1 = never
    logic [DW-1:0] data;       // read data of the target slave
    logic [NS-1:0] exp_sel;
    logic          exp_trap;
    logic          chk_rdata;
    logic [DW-1:0] exp_rdata;
    logic [NS-1:0] spur;       // s_ready bits of slaves that are not selected
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          trap;
    logic          chk_rdata;
    logic [AW-1:0] addr;
    int            start;
    int            lat;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             m_sel;
  logic             m_we;
  logic [AW-1:0]    m_addr;
  logic             m_ready;
  logic [DW-1:0]    m_rdata;
  logic             m_trap;
  logic [AW-1:0]    trap_addr;
  logic [NS-1:0]    s_sel;
  logic [NS-1:0]    s_ready;
  logic [NS*DW-1:0] s_rdata;

  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  vec_t vecs[13];

  xbus_decoder #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .N_SLV    (NS),
    .SLV_BASE (XB_SLV_BASE),
    .SLV_AW   (XB_SLV_AW),
    .TIMEOUT  (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_sel     (m_sel),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .m_trap    (m_trap),
    .trap_addr (trap_addr),
    .s_sel     (s_sel),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_m_ready"}, 32'(m_ready), 32'd0);
    check({tag, "_m_trap"}, 32'(m_trap), 32'd0);
    check({tag, "_m_rdata"}, m_rdata, 32'd0);
    check({tag, "_trap_addr"}, 32'(trap_addr), 32'd0);
    check({tag, "_s_sel"}, 32'(s_sel), 32'd0);
  endtask

  // Scoreboard: every completion pulse is matched against the oldest request.
  always @(negedge clk) begin
    if (m_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("resp addr=0x%0h trap=%0d rdata=0x%0h latency=%0d",
                 e.addr, m_trap, m_rdata, cyc - e.start);
        check("m_trap", 32'(m_trap), 32'(e.trap));
        check("latency", 32'(cyc - e.start), 32'(e.lat));
        if (e.chk_rdata) check("m_rdata", m_rdata, e.rdata);
        if (e.trap) check("trap_addr", 32'(trap_addr), 32'(e.addr));
      end
    end
  end

  task automatic set_rdata(input logic [NS-1:0] tgt, input logic [DW-1:0] data);
    for (int k = 0; k < NS; k++)
      s_rdata[k*DW +: DW] = tgt[k] ? data : (data ^ 32'hFFFF_0000 ^ DW'(k + 1));
  endtask

  task automatic run_vec(input vec_t v);
    int   lat, busy, bad, seen;
    logic done;
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (v.exp_sel == '0) begin
      busy = 0;
      lat  = 1;
    end else if (v.waits < 0) begin
      busy = TO;
      lat  = TO + 1;
    end else begin
      busy = v.waits + 1;
      lat  = v.waits + 2;
    end
    m_addr = v.addr;
    m_we   = v.we;
    m_sel  = 1'b1;
    set_rdata(v.exp_sel, v.data);
    e = '{v.exp_rdata, v.exp_trap, v.chk_rdata, v.addr, cyc, lat};
    sb_q.push_back(e);
    bad  = 0;
    seen = 0;
    done = 1'b0;
    for (int c = 1; c <= TO + 8 && !done; c++) begin
      @(posedge clk);
      #1;
      if (s_sel !== ((c <= busy) ? v.exp_sel : '0)) bad++;
      if (s_sel != '0) seen++;
      if (m_ready) done = 1'b1;
      s_ready = v.spur | ((v.waits >= 0 && c == v.waits + 1) ? v.exp_sel : '0);
    end
    m_sel   = 1'b0;
    s_ready = '0;
    check("ready_seen", 32'(done), 32'd1);
    check("sel_pattern", 32'(bad), 32'd0);
    check("busy_len", 32'(seen), 32'(busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          addr     we    waits data          sel      trap  chk   exp_rdata     spur
    vecs[0]  = '{13'h1004, 1'b0, 0,  32'hDEADBEEF, 4'b0010, 1'b0, 1'b1, 32'hDEADBEEF, 4'b0000};
    vecs[1]  = '{13'h0123, 1'b0, 3,  32'h12345678, 4'b0001, 1'b0, 1'b1, 32'h12345678, 4'b0000};
    vecs[2]  = '{13'h1F00, 1'b0, -1, 32'h00000000, 4'b0000, 1'b1, 1'b0, 32'h00000000, 4'b0000};
    vecs[3]  = '{13'h1010, 1'b0, -1, 32'h77777777, 4'b0010, 1'b1, 1'b1, 32'h00000000, 4'b0000};
    vecs[4]  = '{13'h0ABC, 1'b0, 15, 32'hCAFEF00D, 4'b0001, 1'b0, 1'b1, 32'hCAFEF00D, 4'b0000};
    vecs[5]  = '{13'h0004, 1'b0, 1,  32'h0BADF00D, 4'b0001, 1'b0, 1'b1, 32'h0BADF00D, 4'b0000};
    vecs[6]  = '{13'h10FF, 1'b0, 2,  32'h11223344, 4'b0010, 1'b0, 1'b1, 32'h11223344, 4'b1000};
    vecs[7]  = '{13'h1208, 1'b1, 0,  32'h55AA55AA, 4'b1000, 1'b0, 1'b1, 32'h11223344, 4'b0000};
    vecs[8]  = '{13'h0100, 1'b1, -1, 32'h66666666, 4'b0001, 1'b1, 1'b1, 32'h00000000, 4'b0000};
    vecs[9]  = '{13'h120F, 1'b0, 0,  32'hA5A5A5A5, 4'b1000, 1'b0, 1'b1, 32'hA5A5A5A5, 4'b0000};
    vecs[10] = '{13'h1210, 1'b0, -1, 32'h00000000, 4'b0000, 1'b1, 1'b0, 32'h00000000, 4'b0000};
    vecs[11] = '{13'h0FFF, 1'b0, 4,  32'h3C3C3C3C, 4'b0001, 1'b0, 1'b1, 32'h3C3C3C3C, 4'b0110};
    vecs[12] = '{13'h1100, 1'b0, -1, 32'h00000000, 4'b0000, 1'b1, 1'b0, 32'h00000000, 4'b0000};

    rst_n   = 1'b0;
    m_sel   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    s_ready = '0;
    s_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < $size(vecs); i++) run_vec(vecs[i]);

    // Request held through RESP: re-accepted after IDLE, 3-cycle period.
    @(posedge clk);
    @(negedge clk);
    m_addr = 13'h1040;
    m_we   = 1'b0;
    m_sel  = 1'b1;
    set_rdata(4'b0010, 32'h13579BDF);
    sb_q.push_back('{32'h13579BDF, 1'b0, 1'b1, 13'h1040, cyc, 2});
    sb_q.push_back('{32'h13579BDF, 1'b0, 1'b1, 13'h1040, cyc, 5});
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      s_ready = (c == 1 || c == 4) ? 4'b0010 : 4'b0000;
    end
    m_sel   = 1'b0;
    s_ready = '0;

    // Reset while BUSY: everything clears at once, the access is dropped.
    @(posedge clk);
    @(negedge clk);
    m_addr = 13'h1020;
    m_sel  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_reset", 32'(s_sel), 32'h2);
    rst_n = 1'b0;
    #1;
    check_idle("mid_reset");
    m_sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{13'h1030, 1'b0, 0, 32'h0F0F0F0F, 4'b0010, 1'b0, 1'b1, 32'h0F0F0F0F, 4'b0000});

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
